// File: rtl/dsp_post_round_sat.sv
// dsp_post_round_sat: two-stage post-processing for the DSP48A1 P output.
//   S1 adds the round-half-up constant to the sign-extended 48-bit word.
//   S2 arithmetic-shifts by SHIFT, clips to a signed OUT_W result and flags clipping.
// Handshake: a word moves on any cycle where valid && ready are both high;
//   the producer holds data stable while valid && !ready, and P_READY is
//   combinationally derived from Y_READY only through the S2 load condition.
// Optional saturation event counter (CNT_CLR / SAT_CNT) is built when the
//   macro DSP_POST_SATCNT_EN is defined.
module dsp_post_round_sat #(
   parameter int SHIFT = 17,
   parameter int OUT_W = 18
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [47:0]       P_IN,
   input  logic              P_VALID,
   output logic              P_READY,
`ifdef DSP_POST_SATCNT_EN
   input  logic              CNT_CLR,
   output logic [15:0]       SAT_CNT,
`endif
   output logic [OUT_W-1:0]  Y,
   output logic              Y_SAT,
   output logic              Y_VALID,
   input  logic              Y_READY
);

   // Rounding constant: half an output LSB, or nothing when no bits are dropped.
   localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [48:0] RND   = (SHIFT > 0) ? (49'sd1 <<< RS) : 49'sd0;
   // Clip limits of the signed OUT_W result, expressed in the 49-bit domain.
   localparam logic signed [48:0] MAX_V = (49'sd1 <<< (OUT_W - 1)) - 49'sd1;
   localparam logic signed [48:0] MIN_V = -(49'sd1 <<< (OUT_W - 1));
   localparam logic [OUT_W-1:0]   Y_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]   Y_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   logic                s1_valid;
   logic signed [48:0]  s1_data;
   logic signed [48:0]  rnd_sum;
   logic signed [48:0]  shifted;
   logic                sat_hi;
   logic                sat_lo;
   logic [OUT_W-1:0]    sat_val;
   logic                s2_load;

   // One extra bit of headroom means the rounding add can never overflow.
   assign rnd_sum = $signed({P_IN[47], P_IN}) + RND;

   // S2 takes a new word when it is empty or its current word leaves this cycle.
   assign s2_load = !Y_VALID || Y_READY;
   // S1 frees up when it is empty or its word moves into S2.
   assign P_READY = !s1_valid || s2_load;

   // Shift and clip the rounded S1 word ahead of the S2 register.
   always_comb begin
      shifted = s1_data >>> SHIFT;
      sat_hi  = (shifted > MAX_V);
      sat_lo  = (shifted < MIN_V);
      sat_val = shifted[OUT_W-1:0];
      if (sat_hi) begin
         sat_val = Y_MAX;
      end else if (sat_lo) begin
         sat_val = Y_MIN;
      end
   end

   // S1 register: capture the rounded input whenever the stage can accept.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else if (P_READY) begin
         s1_valid <= P_VALID;
         if (P_VALID) begin
            s1_data <= rnd_sum;
         end
      end
   end

   // S2 register: load the clipped result; Y/Y_SAT hold while stalled.
   always_ff @(posedge CLK) begin
      if (RST) begin
         Y_VALID <= 1'b0;
         Y       <= '0;
         Y_SAT   <= 1'b0;
      end else if (s2_load) begin
         Y_VALID <= s1_valid;
         if (s1_valid) begin
            Y     <= sat_val;
            Y_SAT <= sat_hi | sat_lo;
         end
      end
   end

`ifdef DSP_POST_SATCNT_EN
   // Saturation event counter: counts clipped deliveries, sticks at all-ones, clear wins.
   always_ff @(posedge CLK) begin
      if (RST) begin
         SAT_CNT <= '0;
      end else if (CNT_CLR) begin
         SAT_CNT <= '0;
      end else if (Y_VALID && Y_READY && Y_SAT && (SAT_CNT != 16'hFFFF)) begin
         SAT_CNT <= SAT_CNT + 16'd1;
      end
   end
`endif

endmodule

// File: doc/dsp_post_round_sat.md
DSP_POST_ROUND_SAT -- requirements
Module: dsp_post_round_sat

Interface
REQ-001 The block SHALL take parameter SHIFT, default 17: right-shift applied to the 48-bit product/accumulator, legal range 0..30.
REQ-002 The block SHALL take parameter OUT_W, default 18: signed output width, legal range 8..36.
REQ-003 The block SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port P_IN, input, 48 bits: signed result word from the DSP48A1 P output.
REQ-006 The block SHALL have port P_VALID, input, 1 bit: P_IN is valid this cycle.
REQ-007 The block SHALL have port P_READY, output, 1 bit: the block accepts P_IN this cycle.
REQ-008 The block SHALL have port Y, output, OUT_W bits: rounded, saturated, signed result.
REQ-009 The block SHALL have port Y_SAT, output, 1 bit: Y was clipped.
REQ-010 The block SHALL have port Y_VALID, output, 1 bit: Y and Y_SAT are valid.
REQ-011 The block SHALL have port Y_READY, input, 1 bit: the consumer accepts Y.
REQ-012 The block SHALL have port CNT_CLR, input, 1 bit: clears SAT_CNT; present only under the macro in REQ-026.
REQ-013 The block SHALL have port SAT_CNT, output, 16 bits: saturation event count; present only under the macro in REQ-026.

Function
REQ-014 Transfer rules: input accepted when P_VALID && P_READY; output delivered when Y_VALID && Y_READY.
REQ-015 Pipeline: two registered stages, S1 = round and S2 = saturate/output, each with its own valid bit.
REQ-016 Latency: Y_VALID SHALL assert exactly 2 cycles after acceptance when Y_READY is held high; throughput is 1 sample per cycle.
REQ-017 S2 SHALL load when S2 is empty or delivering this cycle; S1 SHALL load when S1 is empty or moving into S2 this cycle.
REQ-018 P_READY SHALL equal (!S1_valid || S1 advancing); the only combinational path from Y_READY to P_READY is this one.
REQ-019 Upstream SHALL hold P_IN stable while P_VALID && !P_READY; the block SHALL NOT drop, duplicate or reorder samples under any Y_READY pattern.
REQ-020 Rounding (S1): sign-extend P_IN to 49 bits, then add 2^(SHIFT-1) when SHIFT>0 (add nothing when SHIFT=0); the result is round-half-toward-+inf with no overflow.
REQ-021 Shift and saturate (S2): arithmetic right-shift by SHIFT; values above 2^(OUT_W-1)-1 clip to that value and values below -2^(OUT_W-1) clip to that value; Y_SAT=1 when clipped, else 0.
REQ-022 Y and Y_SAT SHALL remain stable while Y_VALID && !Y_READY.

Reset
REQ-023 While RST=1 at a clock edge: both valid bits SHALL clear, Y=0, Y_SAT=0, SAT_CNT=0.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight samples; P_READY=1 on the first cycle after RST deasserts.
REQ-025 RST SHALL take priority over all other inputs, including CNT_CLR and any handshake.

Configuration
REQ-026 With macro DSP_POST_SATCNT_EN defined: SAT_CNT increments by 1 on each delivered sample with Y_SAT=1, holds at 0xFFFF, and is cleared synchronously by CNT_CLR; clear wins over a simultaneous increment.
REQ-027 Without DSP_POST_SATCNT_EN: the CNT_CLR and SAT_CNT ports and the counter logic SHALL be absent; all other behaviour is unchanged.

Verification (SHIFT=17, OUT_W=18)
REQ-028 P_IN=0x000000020000, Y_READY=1 -> 2 cycles later Y=0x00001, Y_SAT=0; P_IN=0x000000010000 -> Y=0x00001 (half rounds up).
REQ-029 P_IN=0xFFFFFFFF0000 (-2^16) -> Y=0x00000; P_IN=0xFFFFFFFE0000 -> Y=0x3FFFF (-1); Y_SAT=0 for both.
REQ-030 P_IN=0x7FFFFFFFFFFF -> Y=0x1FFFF, Y_SAT=1; P_IN=0x800000000000 -> Y=0x20000, Y_SAT=1; SAT_CNT=2 after both are delivered (macro defined).
REQ-031 Stream values 1..6 (each <<17) with Y_READY=0 for 5 cycles, then Y_READY=1 -> P_READY=0 after 2 samples are held; output is exactly 1..6 in order with no gaps once ready.
REQ-032 RST pulsed for 1 cycle with 2 samples in flight -> Y_VALID=0 the next cycle, neither sample ever appears, and the next accepted sample emerges with 2-cycle latency.
REQ-033 Force 65537 saturating deliveries -> SAT_CNT=0xFFFF; CNT_CLR together with a saturating delivery -> SAT_CNT=0 the next cycle.
